// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM encodings and bus constants.
package bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [31:0]  BUS_ERR_DATA = 32'hFFFF_FFFF;
   localparam int unsigned  HW_INT_W     = 6;

endpackage

// File: rtl/addr_decoder.sv
// Combinational address decoder: one-hot hit over N_DEV windows (lowest index wins) plus miss flag.
module addr_decoder #(
   parameter int unsigned           N_DEV      = 2,
   parameter logic [N_DEV*32-1:0]   BASE_ADDRS = {32'h7F10, 32'h7F00},
   parameter int unsigned           WIN_BYTES  = 12
) (
   input  logic [31:0]      addr,
   output logic [N_DEV-1:0] hit,
   output logic             miss
);

   logic [N_DEV-1:0] hit_raw;

   // 33-bit compare so base+WIN_BYTES never wraps.
   for (genvar i = 0; i < N_DEV; i++) begin : g_win
      localparam logic [31:0] BASE = BASE_ADDRS[32*i +: 32];
      assign hit_raw[i] = (addr >= BASE) &&
                          ({1'b0, addr} < (33'(BASE) + 33'(WIN_BYTES)));
   end

   // Isolate the lowest set bit so overlapping windows resolve to the lower index.
   assign hit  = hit_raw & (~hit_raw + N_DEV'(1));
   assign miss = ~|hit_raw;

endmodule

// File: rtl/sys_bridge_multi.sv
// CPU-to-peripheral bridge: decodes, forwards with ready/timeout handshake, registers the
// response, and registers the masked device IRQs into the CP0 hardware interrupt vector.
module sys_bridge_multi
   import bridge_pkg::*;
#(
   parameter int unsigned           N_DEV      = 2,
   parameter logic [N_DEV*32-1:0]   BASE_ADDRS = {32'h7F10, 32'h7F00},
   parameter int unsigned           WIN_BYTES  = 12,
   parameter int unsigned           TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic [31:0]           cpu_addr,
   input  logic                  cpu_we,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_ack,
   output logic                  cpu_err,
   output logic [31:0]           cpu_rdata,
   output logic [N_DEV-1:0]      dev_sel,
   output logic                  dev_we,
   output logic [31:0]           dev_addr,
   output logic [31:0]           dev_wdata,
   input  logic [N_DEV*32-1:0]   dev_rdata,
   input  logic [N_DEV-1:0]      dev_rdy,
   input  logic [N_DEV-1:0]      irq_in,
   input  logic [N_DEV-1:0]      irq_mask,
   input  logic                  ext_int,
   output logic [HW_INT_W-1:0]   hw_int
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [N_DEV-1:0]    hit;
   logic                miss;
   logic                rdy_sel;
   logic [31:0]         rdata_sel;
   logic [HW_INT_W-1:0] hw_int_nxt;

   addr_decoder #(
      .N_DEV      (N_DEV),
      .BASE_ADDRS (BASE_ADDRS),
      .WIN_BYTES  (WIN_BYTES)
   ) u_dec (
      .addr (cpu_addr),
      .hit  (hit),
      .miss (miss)
   );

   // Only the selected device's ready and read slice matter.
   assign rdy_sel = |(dev_rdy & dev_sel);

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (dev_sel[i]) rdata_sel = rdata_sel | dev_rdata[32*i +: 32];
      end
   end

   always_comb begin
      hw_int_nxt                = '0;
      hw_int_nxt[N_DEV-1:0]     = irq_in & irq_mask;
      hw_int_nxt[N_DEV]         = ext_int;
   end

   // Bridge FSM with registered handshake and data outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         dev_sel   <= '0;
         dev_we    <= 1'b0;
         dev_addr  <= '0;
         dev_wdata <= '0;
         hw_int    <= '0;
      end else begin
         hw_int  <= hw_int_nxt;
         cpu_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  dev_addr  <= cpu_addr;
                  dev_wdata <= cpu_wdata;
                  cnt       <= '0;
                  if (miss) begin
                     state     <= ST_RESP;
                     cpu_ack   <= 1'b1;
                     cpu_err   <= 1'b1;
                     cpu_rdata <= BUS_ERR_DATA;
                  end else begin
                     state   <= ST_ACCESS;
                     dev_sel <= hit;
                     dev_we  <= cpu_we;
                  end
               end
            end
            ST_ACCESS: begin
               // Ready in the last counted cycle takes priority over the timeout.
               if (rdy_sel) begin
                  state     <= ST_RESP;
                  cpu_ack   <= 1'b1;
                  cpu_err   <= 1'b0;
                  cpu_rdata <= dev_we ? 32'h0 : rdata_sel;
                  dev_sel   <= '0;
                  dev_we    <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ST_RESP;
                  cpu_ack   <= 1'b1;
                  cpu_err   <= 1'b1;
                  cpu_rdata <= BUS_ERR_DATA;
                  dev_sel   <= '0;
                  dev_we    <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_bridge_multi.sv
// Directed, table-driven bench for sys_bridge_multi with hand-written reset and IRQ sequences.
module tb_sys_bridge_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_we;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic        cpu_err;
   logic [31:0] cpu_rdata;
   logic [1:0]  dev_sel;
   logic        dev_we;
   logic [31:0] dev_addr;
   logic [31:0] dev_wdata;
   logic [63:0] dev_rdata;
   logic [1:0]  dev_rdy;
   logic [1:0]  irq_in;
   logic [1:0]  irq_mask;
   logic        ext_int;
   logic [5:0]  hw_int;

   int checks = 0;
   int errors = 0;

   sys_bridge_multi #(
      .N_DEV      (2),
      .BASE_ADDRS ({32'h7F10, 32'h7F00}),
      .WIN_BYTES  (12),
      .TIMEOUT    (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_err   (cpu_err),
      .cpu_rdata (cpu_rdata),
      .dev_sel   (dev_sel),
      .dev_we    (dev_we),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_rdata (dev_rdata),
      .dev_rdy   (dev_rdy),
      .irq_in    (irq_in),
      .irq_mask  (irq_mask),
      .ext_int   (ext_int),
      .hw_int    (hw_int)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          rdy_at;     // ACCESS cycle (1-based) where selected dev is ready; 0 = never
      int          other_at;   // cycle where the unselected device pulses rdy; 0 = never
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  exp_sel;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;    // cycles from accept edge to the cycle showing ack
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_access(input vec_t v);
      int   lat;
      logic stable;
      cpu_req   = 1'b1;
      cpu_addr  = v.addr;
      cpu_we    = v.we;
      cpu_wdata = v.wdata;
      dev_rdata = {v.rd1, v.rd0};
      dev_rdy   = 2'b00;
      tick();
      cpu_req = 1'b0;   // dropping req mid-access must not abort the transaction
      chk("accept_sel", 32'(dev_sel), 32'(v.exp_sel));
      if (v.exp_sel != 2'b00) begin
         chk("accept_we", 32'(dev_we), 32'(v.we));
         chk("accept_addr", dev_addr, v.addr);
         chk("accept_wdata", dev_wdata, v.wdata);
      end
      lat    = 1;
      stable = 1'b1;
      while (!cpu_ack && lat < 40) begin
         if (dev_sel !== v.exp_sel || dev_we !== v.we) stable = 1'b0;
         dev_rdy = 2'b00;
         if (lat == v.rdy_at)   dev_rdy = dev_rdy | v.exp_sel;
         if (lat == v.other_at) dev_rdy = dev_rdy | ~v.exp_sel;
         tick();
         lat++;
      end
      dev_rdy = 2'b00;
      chk("access_stable", 32'(stable), 32'd1);
      chk("ack_seen", 32'(cpu_ack), 32'd1);
      chk("ack_latency", 32'(lat), 32'(v.exp_lat));
      chk("resp_err", 32'(cpu_err), 32'(v.exp_err));
      chk("resp_rdata", cpu_rdata, v.exp_rdata);
      chk("resp_sel_clear", 32'({dev_sel, dev_we}), 32'd0);
      tick();
      chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
      chk("rdata_hold", cpu_rdata, v.exp_rdata);
   endtask

   initial begin
      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      cpu_we    = 1'b0;
      cpu_wdata = '0;
      dev_rdata = '0;
      dev_rdy   = '0;
      irq_in    = '0;
      irq_mask  = '0;
      ext_int   = 1'b0;

      //         addr          we    wdata  rdy oth  rd0           rd1           sel    err   rdata         lat
      vecs[0] = '{32'h7F04, 1'b0, 32'h0, 1,  0, 32'hDEADBEEF, 32'h11111111, 2'b01, 1'b0, 32'hDEADBEEF, 2};
      vecs[1] = '{32'h7F18, 1'b1, 32'h5, 3,  0, 32'h22222222, 32'h33333333, 2'b10, 1'b0, 32'h00000000, 4};
      vecs[2] = '{32'h7F0C, 1'b0, 32'h0, 0,  0, 32'h44444444, 32'h55555555, 2'b00, 1'b1, 32'hFFFFFFFF, 1};
      vecs[3] = '{32'h7F00, 1'b0, 32'h0, 0,  0, 32'h66666666, 32'h77777777, 2'b01, 1'b1, 32'hFFFFFFFF, 17};
      vecs[4] = '{32'h7F00, 1'b0, 32'h0, 16, 0, 32'hCAFEF00D, 32'h88888888, 2'b01, 1'b0, 32'hCAFEF00D, 17};
      vecs[5] = '{32'h7F1B, 1'b0, 32'h0, 2,  1, 32'h99999999, 32'h12345678, 2'b10, 1'b0, 32'h12345678, 3};
      vecs[6] = '{32'h7F1C, 1'b0, 32'h0, 0,  0, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'b00, 1'b1, 32'hFFFFFFFF, 1};
      vecs[7] = '{32'h0000, 1'b1, 32'h9, 0,  0, 32'hCCCCCCCC, 32'hDDDDDDDD, 2'b00, 1'b1, 32'hFFFFFFFF, 1};
      vecs[8] = '{32'h7F0B, 1'b0, 32'h0, 1,  0, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b01, 1'b0, 32'hA5A5A5A5, 2};

      #23 rst_n = 1'b1;
      tick();
      chk("reset_outputs", 32'({cpu_ack, cpu_err, dev_sel, dev_we, hw_int}), 32'd0);
      chk("reset_rdata", cpu_rdata, 32'd0);
      chk("reset_dev_addr", dev_addr | dev_wdata, 32'd0);

      for (int i = 0; i < 9; i++) do_access(vecs[i]);

      // Request held through RESP: no accept there, accept on the following IDLE cycle.
      cpu_req   = 1'b1;
      cpu_addr  = 32'h7F08;
      cpu_we    = 1'b0;
      dev_rdata = {32'h0, 32'h0BADF00D};
      tick();
      dev_rdy = 2'b01;
      tick();
      dev_rdy = 2'b00;
      chk("b2b_ack", 32'(cpu_ack), 32'd1);
      chk("b2b_rdata", cpu_rdata, 32'h0BADF00D);
      tick();
      chk("b2b_no_accept_in_resp", 32'({cpu_ack, dev_sel}), 32'd0);
      tick();
      cpu_req = 1'b0;
      chk("b2b_second_accept", 32'(dev_sel), 32'd1);
      dev_rdy = 2'b01;
      tick();
      dev_rdy = 2'b00;
      chk("b2b_second_ack", 32'(cpu_ack), 32'd1);
      tick();

      // Masked IRQs with one-cycle registration latency.
      irq_in   = 2'b11;
      irq_mask = 2'b01;
      ext_int  = 1'b1;
      #1;
      chk("irq_registered", 32'(hw_int), 32'd0);
      tick();
      chk("irq_mask01", 32'(hw_int), 32'b000101);
      irq_mask = 2'b11;
      tick();
      chk("irq_mask11", 32'(hw_int), 32'b000111);

      // Reset asserted mid-ACCESS: asynchronous clear, transaction dropped.
      cpu_req   = 1'b1;
      cpu_addr  = 32'h7F00;
      cpu_we    = 1'b1;
      cpu_wdata = 32'hFEEDFACE;
      tick();
      cpu_req = 1'b0;
      tick();
      chk("pre_reset_sel", 32'(dev_sel), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_ctl", 32'({cpu_ack, cpu_err, dev_sel, dev_we, hw_int}), 32'd0);
      chk("async_reset_data", dev_addr | dev_wdata | cpu_rdata, 32'd0);
      dev_rdy = 2'b01;
      tick();
      tick();
      chk("reset_no_ack", 32'(cpu_ack), 32'd0);
      dev_rdy = 2'b00;
      #3 rst_n = 1'b1;
      irq_in  = '0;
      ext_int = 1'b0;
      tick();
      chk("post_reset_idle", 32'({cpu_ack, dev_sel}), 32'd0);
      do_access(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
